// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int CNT_W_DEF   = 16;
  localparam int DEF_DIV_DEF = 1;

  // Width of a channel select; a single channel still needs one select bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: half-period counter, active/shadow divisor pair,
// registered square-wave output and rising-edge tick.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             restart,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_val,
  output logic             clk_d,
  output logic             tick,
  output logic             pend
);

  localparam logic [CNT_W-1:0] DEF_VAL = CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] act_reg;
  logic [CNT_W-1:0] shd_reg;
  logic             clk_d_reg;
  logic             tick_reg;
  logic             pend_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      act_reg   <= DEF_VAL;
      shd_reg   <= DEF_VAL;
      clk_d_reg <= 1'b0;
      tick_reg  <= 1'b0;
      pend_reg  <= 1'b0;
    end else if (restart) begin
      cnt_reg   <= '0;
      clk_d_reg <= 1'b0;
      tick_reg  <= 1'b0;
      pend_reg  <= 1'b0;
      // A same-cycle write bypasses the shadow so the new rate starts now.
      if (wr) begin
        act_reg <= wr_val;
        shd_reg <= wr_val;
      end else begin
        act_reg <= shd_reg;
      end
    end else begin
      tick_reg <= 1'b0;
      if (en) begin
        if (cnt_reg == act_reg) begin
          cnt_reg   <= '0;
          clk_d_reg <= ~clk_d_reg;
          tick_reg  <= ~clk_d_reg;
          if (pend_reg) begin
            act_reg  <= shd_reg;
            pend_reg <= 1'b0;
          end
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
      // Placed last so a write landing on a transfer edge stays pending.
      if (wr) begin
        shd_reg  <= wr_val;
        pend_reg <= 1'b1;
      end
    end
  end

  assign clk_d = clk_d_reg;
  assign tick  = tick_reg;
  assign pend  = pend_reg;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: shared divisor write bus decoded
// to a one-hot write enable, one independent divider per channel.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter  int NCH     = 4,
  parameter  int CNT_W   = CNT_W_DEF,
  parameter  int DEF_DIV = DEF_DIV_DEF,
  localparam int SEL_W   = sel_width(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   en,
  input  logic [NCH-1:0]   restart,
  input  logic             div_wr,
  input  logic [SEL_W-1:0] div_sel,
  input  logic [CNT_W-1:0] div_val,
  output logic [NCH-1:0]   clk_d,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   pend
);

  logic [NCH-1:0] wr_en;

  // Selects at or above NCH match no channel, so such writes are dropped.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      assign wr_en[gi] = div_wr && (div_sel == SEL_W'(gi));

      clk_div_ch #(
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
      ) u_ch (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en[gi]),
        .restart (restart[gi]),
        .wr      (wr_en[gi]),
        .wr_val  (div_val),
        .clk_d   (clk_d[gi]),
        .tick    (tick[gi]),
        .pend    (pend[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: 4-channel main instance plus a 3-channel
// instance used to exercise an out-of-range channel select.
module tb_clk_div_multi;

  logic        clk;
  logic        rst_n;
  logic [3:0]  en;
  logic [3:0]  restart;
  logic        div_wr;
  logic [1:0]  div_sel;
  logic [15:0] div_val;
  logic [3:0]  clk_d;
  logic [3:0]  tick;
  logic [3:0]  pend;

  logic [2:0]  en_b;
  logic [2:0]  restart_b;
  logic        div_wr_b;
  logic [1:0]  div_sel_b;
  logic [15:0] div_val_b;
  logic [2:0]  clk_d_b;
  logic [2:0]  tick_b;
  logic [2:0]  pend_b;

  clk_div_multi #(.NCH(4), .CNT_W(16), .DEF_DIV(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .restart (restart),
    .div_wr  (div_wr),
    .div_sel (div_sel),
    .div_val (div_val),
    .clk_d   (clk_d),
    .tick    (tick),
    .pend    (pend)
  );

  clk_div_multi #(.NCH(3), .CNT_W(16), .DEF_DIV(1)) dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en_b),
    .restart (restart_b),
    .div_wr  (div_wr_b),
    .div_sel (div_sel_b),
    .div_val (div_val_b),
    .clk_d   (clk_d_b),
    .tick    (tick_b),
    .pend    (pend_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Edge count since the last reset release and hand-set waveform segments:
  // channel i toggles every seg_h[i] edges counting from edge seg_s[i], where
  // its output level was seg_p[i].
  int         n;
  int         seg_s [4];
  int         seg_h [4];
  bit         seg_p [4];
  bit         frozen[4];
  logic [3:0] exp_pend;
  int         b_s;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, n, got, exp);
    end
  endtask

  function automatic bit f_clk(input int d, input int h, input bit p);
    return p ^ bit'((d / h) % 2);
  endfunction

  function automatic bit f_tick(input int d, input int h, input bit p);
    return ((d % h) == 0) && f_clk(d, h, p);
  endfunction

  task automatic cycle();
    logic [3:0] e_clk;
    logic [3:0] e_tick;
    logic [2:0] eb_clk;
    logic [2:0] eb_tick;
    @(posedge clk);
    #1;
    n++;
    for (int i = 0; i < 4; i++) begin
      if (frozen[i]) seg_s[i]++;
      e_clk[i]  = f_clk(n - seg_s[i], seg_h[i], seg_p[i]);
      e_tick[i] = frozen[i] ? 1'b0 : f_tick(n - seg_s[i], seg_h[i], seg_p[i]);
    end
    eb_clk  = {3{f_clk(n - b_s, 2, 1'b0)}};
    eb_tick = {3{f_tick(n - b_s, 2, 1'b0)}};
    $display("edge %0d: clk_d=%b tick=%b pend=%b | b: clk_d=%b tick=%b pend=%b",
             n, clk_d, tick, pend, clk_d_b, tick_b, pend_b);
    check("clk_d",   32'(clk_d),   32'(e_clk));
    check("tick",    32'(tick),    32'(e_tick));
    check("pend",    32'(pend),    32'(exp_pend));
    check("clk_d_b", 32'(clk_d_b), 32'(eb_clk));
    check("tick_b",  32'(tick_b),  32'(eb_tick));
    check("pend_b",  32'(pend_b),  32'(3'b000));
  endtask

  task automatic check_cleared(input string tag);
    $display("%s: clk_d=%b tick=%b pend=%b clk_d_b=%b", tag, clk_d, tick, pend, clk_d_b);
    check({tag, "_clk_d"},   32'(clk_d),   32'h0);
    check({tag, "_tick"},    32'(tick),    32'h0);
    check({tag, "_pend"},    32'(pend),    32'h0);
    check({tag, "_clk_d_b"}, 32'(clk_d_b), 32'h0);
  endtask

  // Release between edges with counting enabled; the next edge is edge 1.
  task automatic release_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    en    = 4'hf;
    en_b  = 3'h7;
    n     = 0;
    b_s   = 0;
    exp_pend = 4'h0;
    for (int i = 0; i < 4; i++) begin
      seg_s[i]  = 0;
      seg_h[i]  = 2;
      seg_p[i]  = 1'b0;
      frozen[i] = 1'b0;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 4'h0;
    restart   = 4'h0;
    div_wr    = 1'b0;
    div_sel   = 2'd0;
    div_val   = 16'd0;
    en_b      = 3'h0;
    restart_b = 3'h0;
    div_wr_b  = 1'b0;
    div_sel_b = 2'd0;
    div_val_b = 16'd0;
    n         = 0;

    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    release_reset();

    // Default divisor: period 4 on every channel.
    repeat (8) cycle();

    // Mid-half-period write to ch1: old rate until its next terminal count.
    div_wr = 1'b1; div_sel = 2'd1; div_val = 16'd3; exp_pend = 4'b0010;
    cycle();                                                    // edge 9
    div_wr = 1'b0; exp_pend = 4'b0000;
    seg_s[1] = 10; seg_h[1] = 4; seg_p[1] = 1'b1;
    cycle();                                                    // edge 10
    repeat (9) cycle();                                         // edges 11..19

    // ch2: write 0 on a terminal-count edge (stays pending), overwrite with 5.
    div_wr = 1'b1; div_sel = 2'd2; div_val = 16'd0; exp_pend = 4'b0100;
    cycle();                                                    // edge 20
    div_val = 16'd5;
    cycle();                                                    // edge 21
    div_wr = 1'b0; exp_pend = 4'b0000;
    seg_s[2] = 22; seg_h[2] = 6; seg_p[2] = 1'b1;
    cycle();                                                    // edge 22

    // Select 3 on the 3-channel instance addresses nothing.
    div_wr_b = 1'b1; div_sel_b = 2'd3; div_val_b = 16'd5;
    repeat (2) cycle();                                         // edges 23..24
    div_wr_b = 1'b0;
    cycle();                                                    // edge 25

    // Freeze ch0 mid half-period for 10 edges.
    en[0] = 1'b0; frozen[0] = 1'b1;
    repeat (10) cycle();                                        // edges 26..35
    en[0] = 1'b1; frozen[0] = 1'b0;
    repeat (4) cycle();                                         // edges 36..39

    // ch0 write lands on a terminal count, then restart all with ch3 bypass.
    div_wr = 1'b1; div_sel = 2'd0; div_val = 16'd9; exp_pend = 4'b0001;
    cycle();                                                    // edge 40
    restart = 4'hf; div_sel = 2'd3; div_val = 16'd2; exp_pend = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      seg_s[i] = 41;
      seg_p[i] = 1'b0;
    end
    seg_h[0] = 10; seg_h[1] = 4; seg_h[2] = 6; seg_h[3] = 3;
    cycle();                                                    // edge 41
    restart = 4'h0; div_wr = 1'b0;
    repeat (13) cycle();                                        // edges 42..54

    // Leave a write pending on ch1, then reset asynchronously between edges.
    div_wr = 1'b1; div_sel = 2'd1; div_val = 16'd7; exp_pend = 4'b0010;
    cycle();                                                    // edge 55
    div_wr = 1'b0;
    cycle();                                                    // edge 56
    #3;
    rst_n = 1'b0;
    #1;
    check_cleared("async_reset");
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset_hold");
    release_reset();
    repeat (12) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
